// File: rtl/div_unit_pkg.sv
// Shared constants and types for the execute-stage multi-cycle divider.
package div_unit_pkg;

   // ALU op codes for the two divide flavours, mirrored from the decode stage.
   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } divState_e;

   function automatic logic isDivOp(input logic [7:0] op);
      return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
   endfunction

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage to divider bundle: operation request in, stall/result out.
interface div_unit_if #(parameter int WIDTH = 32);

   logic [7:0]       alucontrol_i;
   logic             valid_i;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             annul_i;
   logic             hold_i;
   logic             stall_o;
   logic             done_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   modport master (
      output alucontrol_i, valid_i, a_i, b_i, annul_i, hold_i,
      input  stall_o, done_o, hi_o, lo_o
   );

   modport slave (
      input  alucontrol_i, valid_i, a_i, b_i, annul_i, hold_i,
      output stall_o, done_o, hi_o, lo_o
   );

endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   remIn_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             dividendBit_i,
   output logic [WIDTH:0]   remOut_o,
   output logic             quotBit_o
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;

   // A set top remainder bit means the shifted value already exceeds any divisor.
   always_comb begin
      shifted   = {remIn_i[WIDTH-1:0], dividendBit_i};
      diff      = {1'b0, shifted} - {2'b00, divisor_i};
      quotBit_o = remIn_i[WIDTH] | ~diff[WIDTH+1];
      remOut_o  = quotBit_o ? diff[WIDTH:0] : shifted;
   end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU; stalls execute while iterating.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       resetn,
   div_unit_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH);

   divState_e        state_q;
   logic [CNT_W-1:0] count_q;
   logic [WIDTH:0]   partRem_q;
   logic [WIDTH-1:0] divQuot_q;
   logic [WIDTH-1:0] divisor_q;
   logic [WIDTH-1:0] aRaw_q;
   logic             qneg_q;
   logic             rneg_q;
   logic             dz_q;
   logic             done_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic             start;
   logic             isSigned;
   logic [WIDTH-1:0] aAbs;
   logic [WIDTH-1:0] bAbs;
   logic [WIDTH:0]   stepRem_d;
   logic             stepQuot_d;
   logic [WIDTH-1:0] quotFinal;
   logic [WIDTH-1:0] remFinal;
   logic [WIDTH-1:0] lo_d;
   logic [WIDTH-1:0] hi_d;

   // divQuot_q starts as |a| and shifts left each step: dividend bits leave at the top, quotient bits enter at the bottom.
   div_step #(.WIDTH(WIDTH)) uStep (
      .remIn_i       (partRem_q),
      .divisor_i     (divisor_q),
      .dividendBit_i (divQuot_q[WIDTH-1]),
      .remOut_o      (stepRem_d),
      .quotBit_o     (stepQuot_d)
   );

   // Start decode, operand magnitudes, and the sign/zero-corrected result of the final step.
   always_comb begin
      start     = (state_q == IDLE) && bus.valid_i && !bus.annul_i && isDivOp(bus.alucontrol_i);
      isSigned  = (bus.alucontrol_i == EXE_DIV_OP);
      aAbs      = (isSigned && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
      bAbs      = (isSigned && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;
      quotFinal = {divQuot_q[WIDTH-2:0], stepQuot_d};
      remFinal  = stepRem_d[WIDTH-1:0];
      lo_d      = dz_q ? '1     : (qneg_q ? -quotFinal : quotFinal);
      hi_d      = dz_q ? aRaw_q : (rneg_q ? -remFinal  : remFinal);
   end

   // Control FSM plus operand, iteration and result registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= IDLE;
         count_q   <= '0;
         partRem_q <= '0;
         divQuot_q <= '0;
         divisor_q <= '0;
         aRaw_q    <= '0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         dz_q      <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= BUSY;
                  divQuot_q <= aAbs;
                  divisor_q <= bAbs;
                  qneg_q    <= isSigned && (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
                  rneg_q    <= isSigned && bus.a_i[WIDTH-1];
                  dz_q      <= (bus.b_i == '0);
                  aRaw_q    <= bus.a_i;
                  count_q   <= '0;
                  partRem_q <= '0;
               end
            end
            BUSY: begin
               if (bus.annul_i) begin
                  state_q <= IDLE;
               end else begin
                  partRem_q <= stepRem_d;
                  divQuot_q <= quotFinal;
                  count_q   <= count_q + 1'b1;
                  if (count_q == CNT_W'(WIDTH - 1)) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     lo_q    <= lo_d;
                     hi_q    <= hi_d;
                  end
               end
            end
            DONE: begin
               if (bus.annul_i || !bus.hold_i) begin
                  state_q <= IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // The start cycle is stalled combinationally; both handshake outputs are quiet during reset.
   always_comb begin
      bus.stall_o = resetn && (start || ((state_q == BUSY) && !bus.annul_i));
      bus.done_o  = resetn && done_q;
      bus.hi_o    = hi_q;
      bus.lo_o    = lo_q;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle divider for the execute stage. It consumes the 8-bit `alucontrol` code produced by the decode-stage ALU decoder, acting only on DIV and DIVU. It runs a 32-iteration restoring division, stalls the pipeline while busy, and delivers the remainder and quotient for the HI/LO register write.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  — the single clock; everything is sampled on its rising edge.
- `resetn`  in  1  — synchronous, active-low reset.
- `alucontrol_i`  in  8  — execute-stage ALU op code; only `EXE_DIV_OP` and `EXE_DIVU_OP` are acted on.
- `valid_i`  in  1  — the execute stage holds a real instruction (not a bubble).
- `a_i`  in  WIDTH  — dividend (rs value).
- `b_i`  in  WIDTH  — divisor (rt value).
- `annul_i`  in  1  — flush or exception; cancels any divide in progress.
- `hold_i`  in  1  — the execute stage is held by a stall from another source.
- `stall_o`  out  1  — holds the execute stage while a divide is in progress.
- `done_o`  out  1  — the result on `hi_o`/`lo_o` is valid this cycle.
- `hi_o`  out  WIDTH  — remainder.
- `lo_o`  out  WIDTH  — quotient.

## Operation
- FSM has three states: IDLE, BUSY, DONE.
- **start** is defined as: `valid_i & !annul_i & (alucontrol_i == EXE_DIV_OP | alucontrol_i == EXE_DIVU_OP)` while the FSM is in IDLE.
- **IDLE → BUSY on start:**
  - Latch `|a|` and `|b|` (plain values for DIVU).
  - Latch the quotient sign `qneg = a[31]^b[31]` and the remainder sign `rneg = a[31]`; both are 0 for DIVU.
  - Latch a divide-by-zero flag `dz = (b_i == 0)` and latch `a_i`.
  - Clear the iteration counter and the partial remainder.
- **BUSY:** one restoring step per cycle.
  - Shift the next dividend bit into the WIDTH+1-bit partial remainder.
  - Trial-subtract the divisor. On a non-negative result, keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - After the WIDTH-th step, go to DONE.
- **DONE:**
  - Register the result: `lo_o = qneg ? -q : q` and `hi_o = rneg ? -r : r`.
  - If `dz` is set, the result is forced to `lo_o = all ones` and `hi_o = latched a_i` for both signed and unsigned; no exception is raised.
  - `done_o = 1` while in DONE.
  - Leave to IDLE when `hold_i = 0`; otherwise stay in DONE. Staying prevents the still-present DIV from restarting.
- **Annul:** `annul_i` in BUSY or DONE sends the FSM to IDLE on the next edge.
  - `done_o` is not asserted in that cycle.
  - `hi_o`/`lo_o` keep their previous values.
  - Annul takes priority over iteration completion.
- **Signed overflow:** `0x80000000 / 0xFFFFFFFF` gives `lo = 0x80000000`, `hi = 0`, with no trap.
- `hi_o`/`lo_o` change only on the edge into DONE and otherwise hold.
- Any `alucontrol_i` other than DIV/DIVU is ignored.

## Timing
- **Reset:** `resetn = 0` at an edge forces IDLE and clears `hi_o`, `lo_o` and the counter.
  - While `resetn = 0`, `stall_o = 0` and `done_o = 0`.
  - Reset mid-BUSY abandons the operation with no output.
- **`stall_o`** = `(IDLE & start) | (BUSY & !annul_i)`. The IDLE term is combinational so the start cycle itself is stalled.
- **Latency:** start at cycle T.
  - BUSY during T+1 … T+32; DONE during T+33.
  - `stall_o` is high T … T+32 (33 cycles) and low at T+33, so the instruction advances at T+33 with `done_o` high.
  - Total execute-stage occupancy is 34 cycles.
- **Back-to-back divides:** the next DIV sees IDLE at T+34 at the earliest (one idle cycle between divides).
- **`hold_i` in DONE:** `done_o` and the outputs stay stable for every cycle that `hold_i` is high.

## Structure
- `EXE_DIV_OP` and `EXE_DIVU_OP` come from the shared `defines.vh`; this block defines no new opcodes.
- The state encoding (2 bits) and the iteration-count width are local constants of the block.
- One sub-module is natural: `div_step`, a purely combinational single restoring iteration.
  - Inputs: partial remainder, divisor, dividend bit.
  - Outputs: next partial remainder and quotient bit.
  - The top level keeps the FSM, the counter, operand and sign registers, and sign correction.

## Test plan
- **Basic DIV:** DIV with a=7, b=2 → `lo_o = 3`, `hi_o = 1`; `stall_o` high exactly 33 cycles; `done_o` in the 34th cycle.
- **Signed vs unsigned:** DIV with a=0xFFFFFFF9, b=2 → `lo_o = 0xFFFFFFFD`, `hi_o = 0xFFFFFFFF`. DIVU with the same operands → `lo_o = 0x7FFFFFFC`, `hi_o = 1`.
- **Overflow and divide-by-zero:**
  - DIV with a=0x80000000, b=0xFFFFFFFF → `lo_o = 0x80000000`, `hi_o = 0`.
  - DIVU with a=5, b=0 → `lo_o = 0xFFFFFFFF`, `hi_o = 5`.
- **Annul mid-divide:** `annul_i` at iteration 10 → `stall_o` low in the same cycle and `done_o` never asserted; `hi_o`/`lo_o` keep the prior result. A following DIV of 100 by 7 yields `lo_o = 14`, `hi_o = 2`.
- **Hold in DONE:** `hold_i` high for 3 cycles in DONE with DIV still on `alucontrol_i` → `done_o` high for 4 cycles, no restart, and `stall_o` stays 0. An ADD code on `alucontrol_i` never asserts `stall_o`.
- **Reset mid-divide:** `resetn` low at iteration 20 → next cycle is IDLE with `hi_o = lo_o = 0` and `stall_o = done_o = 0`.
